// File: rtl/bch_pkg.sv
// Shared constants, FSM encodings and config check for the BCH decoder control.
package bch_pkg;

    localparam int T_MAX = 4;
    localparam int M_MAX = 10;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SYN_RUN = 3'd1;
    localparam logic [2:0] S_SYN_CHK = 3'd2;
    localparam logic [2:0] S_BER_RUN = 3'd3;
    localparam logic [2:0] S_CHN_RUN = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    localparam logic [1:0] ST_CLEAN  = 2'd0;
    localparam logic [1:0] ST_CORR   = 2'd1;
    localparam logic [1:0] ST_UNCORR = 2'd2;
    localparam logic [1:0] ST_FAULT  = 2'd3;

    function automatic logic cfg_bad(
        input logic [9:0] n,
        input logic [3:0] t,
        input logic [3:0] m,
        input int         tmax,
        input int         mmax
    );
        logic [10:0] lim;
        lim = (11'd1 << m) - 11'd1;
        return (t == 4'd0) || (int'(t) > tmax) ||
               (m == 4'd0) || (int'(m) > mmax) ||
               (n == 10'd0) || ({1'b0, n} > lim);
    endfunction

endpackage

// File: rtl/bch_dec_ctrl_wdog.sv
// RUN-state watchdog: cleared on state entry, expires on the WDOG_MAX-th RUN cycle.
module bch_wdog #(
    parameter int WDOG_MAX = 1023
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam int W = $clog2(WDOG_MAX + 1);
    localparam logic [W-1:0] LIM = W'(WDOG_MAX - 1);

    logic [W-1:0] cnt;

    assign expire = en && (cnt == LIM);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && !expire)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/bch_dec_ctrl.sv
// Frame sequencer for the hard-decision BCH decoder:
// syndrome -> Berlekamp-Massey -> Chien, with early exit on clean frames.
module bch_dec_ctrl #(
    parameter int T_MAX    = bch_pkg::T_MAX,
    parameter int M_MAX    = bch_pkg::M_MAX,
    parameter int WDOG_MAX = 1023
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [9:0]               in_n,
    input  logic [3:0]               in_t,
    input  logic [3:0]               in_m,
    output logic [9:0]               cfg_n,
    output logic [3:0]               cfg_t,
    output logic [3:0]               cfg_m,
    output logic                     syn_start,
    input  logic                     syn_done,
    input  logic [2*T_MAX*M_MAX-1:0] syndromes,
    output logic                     ber_start,
    input  logic                     ber_done,
    input  logic                     ber_fail,
    input  logic [3:0]               ber_deg,
    output logic                     chien_start,
    input  logic                     chien_done,
    input  logic [3:0]               chien_err_cnt,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [1:0]               out_status,
    output logic [3:0]               out_err_cnt,
    output logic                     busy
);
    import bch_pkg::*;

    logic [2:0] state, nst;
    logic       ent, zero, fault, syn_or, acc, run, wd_exp;
    logic [3:0] deg, ecnt_n;
    logic [1:0] status_n;

    assign acc = (state == S_IDLE) && in_valid && in_ready;
    assign run = (state == S_SYN_RUN) || (state == S_BER_RUN) ||
                 (state == S_CHN_RUN);

    // ent marks the first cycle of a state; dones seen then are ignored
    assign syn_start   = ent && (state == S_SYN_RUN);
    assign ber_start   = ent && (state == S_BER_RUN);
    assign chien_start = ent && (state == S_CHN_RUN);
    assign out_valid   = (state == S_DONE);
    assign busy        = (state != S_IDLE);

    bch_wdog #(.WDOG_MAX(WDOG_MAX)) u_wdog (
        .clk    (clk),
        .rstn   (rstn),
        .clr    (nst != state),
        .en     (run),
        .expire (wd_exp)
    );

    always_comb begin
        syn_or = 1'b0;
        for (int i = 0; i < 2*T_MAX; i++)
            if (i < 2*int'(cfg_t))
                syn_or = syn_or | (|syndromes[i*M_MAX +: M_MAX]);
    end

    always_comb begin
        nst      = state;
        status_n = out_status;
        ecnt_n   = out_err_cnt;
        unique case (state)
            S_IDLE: begin
                if (acc)
                    nst = cfg_bad(in_n, in_t, in_m, T_MAX, M_MAX) ?
                          S_SYN_CHK : S_SYN_RUN;
            end
            S_SYN_RUN: begin
                if (!ent && syn_done) begin
                    nst = S_SYN_CHK;
                end else if (wd_exp) begin
                    nst = S_DONE; status_n = ST_FAULT; ecnt_n = 4'd0;
                end
            end
            S_SYN_CHK: begin
                if (fault) begin
                    nst = S_DONE; status_n = ST_FAULT; ecnt_n = 4'd0;
                end else if (zero) begin
                    nst = S_DONE; status_n = ST_CLEAN; ecnt_n = 4'd0;
                end else begin
                    nst = S_BER_RUN;
                end
            end
            S_BER_RUN: begin
                if (!ent && ber_done) begin
                    if (ber_fail || ber_deg == 4'd0 || ber_deg > cfg_t) begin
                        nst = S_DONE; status_n = ST_UNCORR; ecnt_n = 4'd0;
                    end else begin
                        nst = S_CHN_RUN;
                    end
                end else if (wd_exp) begin
                    nst = S_DONE; status_n = ST_FAULT; ecnt_n = 4'd0;
                end
            end
            S_CHN_RUN: begin
                nst = state;
                if (!ent && chien_done) begin
                    nst = S_DONE;
                    if (chien_err_cnt != deg) begin
                        status_n = ST_UNCORR; ecnt_n = 4'd0;
                    end else begin
                        status_n = ST_CORR; ecnt_n = chien_err_cnt;
                    end
                end else if (wd_exp) begin
                    nst = S_DONE; status_n = ST_FAULT; ecnt_n = 4'd0;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    nst = S_IDLE; status_n = ST_CLEAN; ecnt_n = 4'd0;
                end
            end
            default: nst = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= S_IDLE;
            ent         <= 1'b0;
            in_ready    <= 1'b0;
            cfg_n       <= '0;
            cfg_t       <= '0;
            cfg_m       <= '0;
            zero        <= 1'b0;
            fault       <= 1'b0;
            deg         <= '0;
            out_status  <= '0;
            out_err_cnt <= '0;
        end else begin
            state       <= nst;
            ent         <= (nst != state);
            in_ready    <= (nst == S_IDLE);
            out_status  <= status_n;
            out_err_cnt <= ecnt_n;
            if (acc) begin
                cfg_n <= in_n;
                cfg_t <= in_t;
                cfg_m <= in_m;
                fault <= cfg_bad(in_n, in_t, in_m, T_MAX, M_MAX);
            end
            if (state == S_SYN_RUN && !ent && syn_done)
                zero <= !syn_or;
            if (state == S_BER_RUN && !ent && ber_done)
                deg <= ber_deg;
        end
    end

endmodule

// File: tb/tb_bch_dec_ctrl.sv
// Directed bench for bch_dec_ctrl: engines emulated inline, results scoreboarded.
module tb_bch_dec_ctrl;

    localparam int TM = 4;
    localparam int MM = 10;
    localparam int WD = 1023;

    localparam logic [1:0] CLEAN  = 2'd0;
    localparam logic [1:0] CORR   = 2'd1;
    localparam logic [1:0] UNCORR = 2'd2;
    localparam logic [1:0] FAULT  = 2'd3;

    logic             clk = 1'b0;
    logic             rstn;
    logic             in_valid, in_ready;
    logic [9:0]       in_n, cfg_n;
    logic [3:0]       in_t, in_m, cfg_t, cfg_m;
    logic             syn_start, syn_done;
    logic [2*TM*MM-1:0] syndromes;
    logic             ber_start, ber_done, ber_fail;
    logic [3:0]       ber_deg;
    logic             chien_start, chien_done;
    logic [3:0]       chien_err_cnt;
    logic             out_valid, out_ready;
    logic [1:0]       out_status;
    logic [3:0]       out_err_cnt;
    logic             busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t_acc = 0;
    int syn_n = 0, ber_n = 0, chn_n = 0;
    int s0, b0, c0;
    int lat;
    logic [5:0] exp_q[$];

    bch_dec_ctrl #(.T_MAX(TM), .M_MAX(MM), .WDOG_MAX(WD)) dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_n(in_n), .in_t(in_t), .in_m(in_m),
        .cfg_n(cfg_n), .cfg_t(cfg_t), .cfg_m(cfg_m),
        .syn_start(syn_start), .syn_done(syn_done), .syndromes(syndromes),
        .ber_start(ber_start), .ber_done(ber_done),
        .ber_fail(ber_fail), .ber_deg(ber_deg),
        .chien_start(chien_start), .chien_done(chien_done),
        .chien_err_cnt(chien_err_cnt),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_status(out_status), .out_err_cnt(out_err_cnt),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rstn) begin
            if (syn_start)   syn_n <= syn_n + 1;
            if (ber_start)   ber_n <= ber_n + 1;
            if (chien_start) chn_n <= chn_n + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic snap();
        s0 = syn_n; b0 = ber_n; c0 = chn_n;
    endtask

    task automatic starts(input int s, input int b, input int c);
        chk("syn_starts", 32'(syn_n - s0), 32'(s));
        chk("ber_starts", 32'(ber_n - b0), 32'(b));
        chk("chien_starts", 32'(chn_n - c0), 32'(c));
    endtask

    task automatic accept(input logic [9:0] n, input logic [3:0] t,
                          input logic [3:0] m);
        int g;
        g = 0;
        in_n = n; in_t = t; in_m = m; in_valid = 1'b1;
        while (!in_ready && g < 20) begin
            tick();
            g++;
        end
        chk("in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        t_acc = cyc;
    endtask

    task automatic finish_frame(input int hold, output int l);
        logic [5:0] o, e;
        int g;
        g = 0;
        out_ready = (hold == 0);
        while (!out_valid && g < 2000) begin
            tick();
            g++;
        end
        chk("out_valid", 32'(out_valid), 32'd1);
        l = cyc - t_acc;
        o = {out_status, out_err_cnt};
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 6'h3f;
        chk("result", 32'(o), 32'(e));
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_result", 32'({out_status, out_err_cnt}), 32'(e));
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        chk("post_valid", 32'(out_valid), 32'd0);
        chk("post_in_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic syn_only(input logic [9:0] n, input logic [3:0] t,
                            input logic [3:0] m, input int lsyn);
        accept(n, t, m);
        chk("syn_start", 32'(syn_start), 32'd1);
        repeat (lsyn) tick();
        syn_done = 1'b1;
        tick();
        syn_done = 1'b0;
    endtask

    task automatic full(input logic [3:0] t, input logic [2*TM*MM-1:0] syn,
                        input logic bfail, input logic [3:0] bdeg,
                        input logic [3:0] ccnt, input logic chn,
                        input int hold);
        int l;
        syndromes = syn;
        syn_only(10'd1023, t, 4'd10, 2);
        tick();
        chk("ber_start", 32'(ber_start), 32'd1);
        ber_done = 1'b1; ber_fail = 1'b1;
        tick();
        ber_done = 1'b0;
        ber_fail = bfail; ber_deg = bdeg;
        repeat (2) tick();
        ber_done = 1'b1;
        tick();
        ber_done = 1'b0; ber_fail = 1'b0;
        if (chn) begin
            chk("chien_start", 32'(chien_start), 32'd1);
            repeat (3) tick();
            chien_err_cnt = ccnt; chien_done = 1'b1;
            tick();
            chien_done = 1'b0;
        end
        finish_frame(hold, l);
    endtask

    initial begin
        logic [2*TM*MM-1:0] s_one;
        s_one = '0;
        s_one[9:0] = 10'h1;
        in_valid = 0; in_n = 0; in_t = 0; in_m = 0;
        syn_done = 0; syndromes = '0;
        ber_done = 0; ber_fail = 0; ber_deg = 0;
        chien_done = 0; chien_err_cnt = 0;
        out_ready = 1; rstn = 0;
        repeat (3) tick();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_status", 32'(out_status), 32'd0);
        chk("rst_cfg_n", 32'(cfg_n), 32'd0);
        chk("rst_syn_start", 32'(syn_start), 32'd0);
        rstn = 1;
        tick();
        chk("idle_in_ready", 32'(in_ready), 32'd1);

        syn_done = 1; ber_done = 1; chien_done = 1;
        tick();
        syn_done = 0; ber_done = 0; chien_done = 0;
        tick();
        chk("stray_busy", 32'(busy), 32'd0);
        chk("stray_valid", 32'(out_valid), 32'd0);

        snap();
        exp_q.push_back({CLEAN, 4'd0});
        syn_only(10'd1023, 4'd4, 4'd10, 4);
        chk("cfg_n", 32'(cfg_n), 32'd1023);
        chk("cfg_t", 32'(cfg_t), 32'd4);
        chk("cfg_m", 32'(cfg_m), 32'd10);
        finish_frame(0, lat);
        chk("clean_latency", 32'(lat), 32'd6);
        starts(1, 0, 0);

        snap();
        exp_q.push_back({CORR, 4'd3});
        full(4'd4, s_one, 1'b0, 4'd3, 4'd3, 1'b1, 0);
        starts(1, 1, 1);
        exp_q.push_back({UNCORR, 4'd0});
        full(4'd4, s_one, 1'b0, 4'd3, 4'd2, 1'b1, 0);

        snap();
        syndromes = '0;
        syndromes[4*MM +: MM] = 10'h2a5;
        exp_q.push_back({CLEAN, 4'd0});
        syn_only(10'd1023, 4'd2, 4'd10, 3);
        finish_frame(0, lat);
        starts(1, 0, 0);
        snap();
        exp_q.push_back({UNCORR, 4'd0});
        full(4'd4, s_one, 1'b1, 4'd2, 4'd0, 1'b0, 0);
        starts(1, 1, 0);
        exp_q.push_back({UNCORR, 4'd0});
        full(4'd2, s_one, 1'b0, 4'd3, 4'd0, 1'b0, 0);
        exp_q.push_back({UNCORR, 4'd0});
        full(4'd4, s_one, 1'b0, 4'd0, 4'd0, 1'b0, 0);

        snap();
        exp_q.push_back({FAULT, 4'd0});
        accept(10'd100, 4'd4, 4'd6);
        finish_frame(0, lat);
        chk("badcfg_latency", 32'(lat), 32'd1);
        exp_q.push_back({FAULT, 4'd0});
        accept(10'd1023, 4'd5, 4'd10);
        finish_frame(0, lat);
        starts(0, 0, 0);
        syndromes = '0;
        exp_q.push_back({CLEAN, 4'd0});
        syn_only(10'd63, 4'd4, 4'd6, 1);
        finish_frame(0, lat);

        exp_q.push_back({FAULT, 4'd0});
        accept(10'd1023, 4'd4, 4'd10);
        chk("wd_syn_start", 32'(syn_start), 32'd1);
        finish_frame(0, lat);
        chk("wd_latency", 32'(lat), 32'(WD));
        exp_q.push_back({CLEAN, 4'd0});
        accept(10'd1023, 4'd4, 4'd10);
        repeat (WD - 1) tick();
        syn_done = 1;
        tick();
        syn_done = 0;
        finish_frame(0, lat);
        chk("wd_race_latency", 32'(lat), 32'(WD + 1));

        exp_q.push_back({CORR, 4'd2});
        full(4'd4, s_one, 1'b0, 4'd2, 4'd2, 1'b1, 10);

        snap();
        syndromes = s_one;
        syn_only(10'd1023, 4'd4, 4'd10, 2);
        tick();
        chk("rst_ber_start", 32'(ber_start), 32'd1);
        repeat (3) tick();
        rstn = 0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd0);
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_cfg_n", 32'(cfg_n), 32'd0);
        chk("abort_ber_start", 32'(ber_start), 32'd0);
        tick();
        rstn = 1;
        ber_done = 1; ber_deg = 4'd1;
        tick();
        ber_done = 0;
        tick();
        chk("abort_idle", 32'(busy), 32'd0);
        chk("abort_no_result", 32'(out_valid), 32'd0);
        syndromes = '0;
        exp_q.push_back({CLEAN, 4'd0});
        syn_only(10'd1023, 4'd4, 4'd10, 3);
        finish_frame(0, lat);
        chk("after_reset_latency", 32'(lat), 32'd5);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
